// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and helpers for the programmable sequence detector
package seq_det_pkg;

  // Detection mode: OVERLAP keeps history after a match, NONOVERLAP restarts it
  typedef enum logic {
    MODE_OVERLAP    = 1'b0,
    MODE_NONOVERLAP = 1'b1
  } t_det_mode;

  // Widest counter the saturating helper supports
  localparam int unsigned SAT_MAX_W = 32;

  // Saturating increment of a value held in the low 'width' bits
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] val,
                                                   input int unsigned width);
    logic [SAT_MAX_W-1:0] max_v;
    if (width >= SAT_MAX_W) begin
      max_v = '1;
    end else begin
      max_v = (32'd1 << width) - 32'd1;
    end
    if (val >= max_v) begin
      return max_v;
    end
    return val + 32'd1;
  endfunction

endpackage

// File: rtl/seq_det_match_cnt.sv
// rtl/seq_det_match_cnt.sv - saturating match counter with priority clear
module seq_det_match_cnt
  import seq_det_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear wins over a simultaneous increment; increment sticks at all ones
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = CNT_W'(sat_inc(SAT_MAX_W'(count_q), CNT_W));
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_det_prog.sv
// rtl/seq_det_prog.sv - runtime-programmable serial pattern detector
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int unsigned          SEQ_LEN     = 8,
  parameter logic [SEQ_LEN-1:0]   DEF_PATTERN = 8'b10011001,
  parameter int unsigned          CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_wr,
  input  logic [SEQ_LEN-1:0] cfg_pattern,
  input  logic [SEQ_LEN-1:0] cfg_mask,
  input  logic               cfg_mode,
  input  logic               in_valid,
  input  logic               in_data,
  input  logic               cnt_clr,
  output logic               det_pulse,
  output logic [CNT_W-1:0]   det_count
);

  localparam int unsigned           FILL_W    = $clog2(SEQ_LEN + 1);
  localparam logic [FILL_W-1:0]     FILL_FULL = FILL_W'(SEQ_LEN);

  logic [SEQ_LEN-1:0] pattern_q, pattern_d;
  logic [SEQ_LEN-1:0] mask_q, mask_d;
  t_det_mode          mode_q, mode_d;
  logic [SEQ_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               det_pulse_q, det_pulse_d;

  logic [SEQ_LEN-1:0] hist_nxt;
  logic [FILL_W-1:0]  fill_inc;
  logic               match;

  // Candidate window and masked compare for the bit presented this cycle;
  // a config write drops the bit, so it can never match
  always_comb begin
    hist_nxt = {hist_q[SEQ_LEN-2:0], in_data};
    fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    match    = in_valid && !cfg_wr && (fill_inc == FILL_FULL) &&
               (((hist_nxt ^ pattern_q) & mask_q) == '0);
  end

  // Next-state for config, history, fill level and the registered pulse
  always_comb begin
    pattern_d   = pattern_q;
    mask_d      = mask_q;
    mode_d      = mode_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    det_pulse_d = match;
    if (cfg_wr) begin
      pattern_d = cfg_pattern;
      mask_d    = cfg_mask;
      mode_d    = t_det_mode'(cfg_mode);
      hist_d    = '0;
      fill_d    = '0;
    end else if (in_valid) begin
      hist_d = hist_nxt;
      if (match && (mode_q == MODE_NONOVERLAP)) begin
        fill_d = '0;
      end else begin
        fill_d = fill_inc;
      end
    end
  end

  // State registers; reset discards any partial pattern and pending pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q   <= DEF_PATTERN;
      mask_q      <= '1;
      mode_q      <= MODE_OVERLAP;
      hist_q      <= '0;
      fill_q      <= '0;
      det_pulse_q <= 1'b0;
    end else begin
      pattern_q   <= pattern_d;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      det_pulse_q <= det_pulse_d;
    end
  end

  seq_det_match_cnt #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (match),
    .count (det_count)
  );

  assign det_pulse = det_pulse_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// tb/tb_seq_det_prog.sv - self-checking bench for seq_det_prog
module tb_seq_det_prog;

  typedef struct {
    logic       w;
    logic [7:0] pat;
    logic [7:0] msk;
    logic       mode;
    logic       v;
    logic       d;
    logic       clr;
    logic       exp_p;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr;
  logic [7:0]  cfg_pattern;
  logic [7:0]  cfg_mask;
  logic        cfg_mode;
  logic        in_valid;
  logic        in_data;
  logic        cnt_clr;
  logic        det_pulse_a, det_pulse_b;
  logic [15:0] det_count_a;
  logic [1:0]  det_count_b;

  int          checks = 0;
  int          failures = 0;
  logic        exp_q[$];
  int unsigned exp_cnt_a = 0;
  int unsigned exp_cnt_b = 0;
  logic [7:0]  cur_pat = 8'b10011001;
  logic [7:0]  cur_msk = 8'hFF;
  logic        cur_mode = 1'b0;
  vec_t        tbl[$];

  always #5 clk = ~clk;

  seq_det_prog #(.SEQ_LEN(8), .DEF_PATTERN(8'b10011001), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_pattern(cfg_pattern),
    .cfg_mask(cfg_mask), .cfg_mode(cfg_mode), .in_valid(in_valid),
    .in_data(in_data), .cnt_clr(cnt_clr), .det_pulse(det_pulse_a),
    .det_count(det_count_a)
  );

  seq_det_prog #(.SEQ_LEN(8), .DEF_PATTERN(8'b10011001), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_pattern(cfg_pattern),
    .cfg_mask(cfg_mask), .cfg_mode(cfg_mode), .in_valid(in_valid),
    .in_data(in_data), .cnt_clr(cnt_clr), .det_pulse(det_pulse_b),
    .det_count(det_count_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, queue the expected pulse, compare after the edge
  task automatic step(input vec_t vc, input string tag);
    logic e;
    @(negedge clk);
    cfg_wr      = vc.w;
    cfg_pattern = vc.pat;
    cfg_mask    = vc.msk;
    cfg_mode    = vc.mode;
    in_valid    = vc.v;
    in_data     = vc.d;
    cnt_clr     = vc.clr;
    exp_q.push_back(vc.exp_p);
    if (vc.w) begin
      cur_pat  = vc.pat;
      cur_msk  = vc.msk;
      cur_mode = vc.mode;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_pulse_a"}, {31'd0, det_pulse_a}, {31'd0, e});
      chk({tag, "_pulse_b"}, {31'd0, det_pulse_b}, {31'd0, e});
      if (vc.clr) begin
        exp_cnt_a = 0;
        exp_cnt_b = 0;
      end else if (e) begin
        if (exp_cnt_a < 65535) exp_cnt_a++;
        if (exp_cnt_b < 3) exp_cnt_b++;
      end
      chk({tag, "_count_a"}, {16'd0, det_count_a}, exp_cnt_a);
      chk({tag, "_count_b"}, {30'd0, det_count_b}, exp_cnt_b);
    end
  endtask

  task automatic bitc(input logic v, input logic d, input logic clr, input logic exp_p,
                      input string tag);
    vec_t vc;
    vc = '{1'b0, cur_pat, cur_msk, cur_mode, v, d, clr, exp_p};
    step(vc, tag);
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [7:0] msk, input logic mode,
                     input logic v, input logic d, input string tag);
    vec_t vc;
    vc = '{1'b1, pat, msk, mode, v, d, 1'b0, 1'b0};
    step(vc, tag);
  endtask

  task automatic reset_cycle(input logic v, input logic d, input string tag);
    @(negedge clk);
    rst      = 1'b1;
    cfg_wr   = 1'b0;
    in_valid = v;
    in_data  = d;
    cnt_clr  = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_pulse_a"}, {31'd0, det_pulse_a}, 32'd0);
    chk({tag, "_pulse_b"}, {31'd0, det_pulse_b}, 32'd0);
    chk({tag, "_count_a"}, {16'd0, det_count_a}, 32'd0);
    chk({tag, "_count_b"}, {30'd0, det_count_b}, 32'd0);
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    cur_pat   = 8'b10011001;
    cur_msk   = 8'hFF;
    cur_mode  = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] dp;
    logic [7:0] grp;
    dp = 8'b10011001;

    // Overlap: 10011001 then 1001 -> pulses on bit 8 and bit 12
    for (int i = 0; i < 8; i++) tbl.push_back('{1'b0, dp, 8'hFF, 1'b0, 1'b1, dp[7-i], 1'b0, i == 7});
    for (int i = 0; i < 4; i++) tbl.push_back('{1'b0, dp, 8'hFF, 1'b0, 1'b1, dp[7-i], 1'b0, i == 3});
    // Non-overlap: same 12 bits -> only bit 8 matches
    tbl.push_back('{1'b1, dp, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 8; i++) tbl.push_back('{1'b0, dp, 8'hFF, 1'b1, 1'b1, dp[7-i], 1'b0, i == 7});
    for (int i = 0; i < 4; i++) tbl.push_back('{1'b0, dp, 8'hFF, 1'b1, 1'b1, dp[7-i], 1'b0, 1'b0});
    tbl.push_back('{1'b1, dp, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    rst = 1'b1; cfg_wr = 1'b0; cfg_pattern = '0; cfg_mask = '0; cfg_mode = 1'b0;
    in_valid = 1'b0; in_data = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pulse_a", {31'd0, det_pulse_a}, 32'd0);
    chk("reset_count_a", {16'd0, det_count_a}, 32'd0);
    chk("reset_count_b", {30'd0, det_count_b}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("tbl%0d", i));

    // Valid gaps of 0-3 idle cycles between bits -> single pulse after last bit
    cfg(dp, 8'hFF, 1'b0, 1'b0, 1'b0, "gap_cfg");
    for (int i = 0; i < 8; i++) begin
      bitc(1'b1, dp[7-i], 1'b0, i == 7, $sformatf("gap_bit%0d", i));
      if (i < 7) begin
        int n;
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) bitc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "gap_idle");
      end
    end
    bitc(1'b0, 1'b0, 1'b0, 1'b0, "gap_after");

    // Masked pattern A5/F0: any 1010_xxxx matches
    for (int g = 0; g < 4; g++) begin
      grp = {4'b1010, 4'($urandom_range(0, 15))};
      cfg(8'hA5, 8'hF0, 1'b0, 1'b0, 1'b0, "mask_cfg");
      for (int i = 0; i < 8; i++) bitc(1'b1, grp[7-i], 1'b0, i == 7, $sformatf("mask_g%0d_b%0d", g, i));
    end
    // Config write mid-pattern discards the partial window
    grp = 8'b1010_0110;
    cfg(8'hA5, 8'hF0, 1'b0, 1'b0, 1'b0, "mid_cfg0");
    for (int i = 0; i < 7; i++) bitc(1'b1, grp[7-i], 1'b0, 1'b0, "mid_pre");
    cfg(8'hA5, 8'hF0, 1'b0, 1'b0, 1'b0, "mid_cfg1");
    bitc(1'b1, grp[0], 1'b0, 1'b0, "mid_last");
    // Config write with a valid bit drops that bit
    grp = 8'b1010_0000;
    cfg(8'hA5, 8'hF0, 1'b0, 1'b1, 1'b1, "drop_cfg");
    for (int i = 1; i < 8; i++) bitc(1'b1, grp[7-i], 1'b0, 1'b0, "drop_bits");

    // mask=0: every bit matches once full; 2-bit counter saturates; clear wins
    bitc(1'b0, 1'b0, 1'b1, 1'b0, "sat_clr0");
    cfg(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "sat_cfg");
    for (int i = 0; i < 7; i++) bitc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "sat_fill");
    for (int i = 0; i < 5; i++) bitc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, $sformatf("sat_m%0d", i));
    bitc(1'b1, 1'b1, 1'b1, 1'b1, "clr_with_match");
    bitc(1'b1, 1'b0, 1'b0, 1'b1, "after_clr");

    // Reset after 7 of 8 bits with the 8th bit presented: no pulse, count 0
    cfg(dp, 8'hFF, 1'b0, 1'b0, 1'b0, "rst_cfg");
    for (int i = 0; i < 7; i++) bitc(1'b1, dp[7-i], 1'b0, 1'b0, "rst_pre");
    reset_cycle(1'b1, dp[0], "rst_mid");
    bitc(1'b1, dp[0], 1'b0, 1'b0, "rst_last");
    // Reset restored the default pattern and overlap mode
    for (int i = 0; i < 8; i++) bitc(1'b1, dp[7-i], 1'b0, i == 7, "rst_default");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
